// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared state encoding, pixel and score constants for game_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

   localparam int              RGB_W   = 12;
   localparam logic [RGB_W-1:0] BLACK  = 12'h000;
   localparam int              SCORE_W = 4;

   typedef enum logic [2:0] {
      ST_TITLE     = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_OVER_HOLD = 3'd3,
      ST_OVER      = 3'd4
   } state_t;

   // Scores stop at the winning value so they can never wrap.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] score,
                                                 input logic [SCORE_W-1:0] limit);
      sat_inc = (score >= limit) ? limit : score + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl_if
// Purpose  : Pixel streams, player events and game status around game_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface game_ctrl_if;
   import game_pkg::*;

   logic               p_tick;
   logic               video_on;
   logic               start;
   logic               restart;
   logic               miss_p1;
   logic               miss_p2;
   logic [RGB_W-1:0]   rgb_title;
   logic [RGB_W-1:0]   rgb_play;
   logic [RGB_W-1:0]   rgb_over;
   logic [RGB_W-1:0]   rgb;
   logic               game_active;
   logic               ball_reset;
   logic [SCORE_W-1:0] score1;
   logic [SCORE_W-1:0] score2;
   logic               winner;

   // Controller side.
   modport slave (
      input  p_tick, video_on, start, restart, miss_p1, miss_p2,
      input  rgb_title, rgb_play, rgb_over,
      output rgb, game_active, ball_reset, score1, score2, winner
   );

   // Surrounding system side.
   modport master (
      output p_tick, video_on, start, restart, miss_p1, miss_p2,
      output rgb_title, rgb_play, rgb_over,
      input  rgb, game_active, ball_reset, score1, score2, winner
   );

endinterface
`default_nettype wire

// File: rtl/game_ctrl_edge_rise.sv
`default_nettype none
// ============================================================================
// Module   : edge_rise
// Purpose  : Rising-edge detector; history resets high so a held level is
//            not seen as an edge after reset.
// Revision : 1.0 - initial release
// ============================================================================
module edge_rise (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic din,
   output logic      rise
);

   logic r_q;

   always_ff @(posedge clk) begin
      if (reset) r_q <= 1'b1;
      else       r_q <= din;
   end

   assign rise = din & ~r_q;

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Game flow sequencer (title, serve, play, game over), scores,
//            motion gating and registered RGB output mux.
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl
   import game_pkg::*;
#(
   parameter int WIN_SCORE      = 7,
   parameter int SERVE_DELAY    = 25_000_000,
   parameter int HOLDOFF_CYCLES = 25_000_000
) (
   input  wire logic clk,
   input  wire logic reset,
   game_ctrl_if.slave bus
);

   localparam int c_CNT_W = $clog2((SERVE_DELAY > HOLDOFF_CYCLES) ? SERVE_DELAY
                                                                   : HOLDOFF_CYCLES) + 1;
   localparam logic [c_CNT_W-1:0] c_SERVE_LOAD = c_CNT_W'(SERVE_DELAY - 1);
   localparam logic [c_CNT_W-1:0] c_HOLD_LOAD  = c_CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [SCORE_W-1:0] c_WIN        = SCORE_W'(WIN_SCORE);

   state_t             r_state, w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [SCORE_W-1:0] r_score1, w_score1_nxt;
   logic [SCORE_W-1:0] r_score2, w_score2_nxt;
   logic               r_winner, w_winner_nxt;
   logic [RGB_W-1:0]   r_rgb, w_pix;
   logic               w_start_rise, w_restart_rise;
   logic [SCORE_W-1:0] w_inc1, w_inc2;

   edge_rise u_start_edge (
      .clk   (clk),
      .reset (reset),
      .din   (bus.start),
      .rise  (w_start_rise)
   );

   edge_rise u_restart_edge (
      .clk   (clk),
      .reset (reset),
      .din   (bus.restart),
      .rise  (w_restart_rise)
   );

   assign w_inc1 = sat_inc(r_score1, c_WIN);
   assign w_inc2 = sat_inc(r_score2, c_WIN);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_TITLE;
         r_cnt    <= '0;
         r_score1 <= '0;
         r_score2 <= '0;
         r_winner <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_score1 <= w_score1_nxt;
         r_score2 <= w_score2_nxt;
         r_winner <= w_winner_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_score1_nxt = r_score1;
      w_score2_nxt = r_score2;
      w_winner_nxt = r_winner;
      case (r_state)
         ST_TITLE: begin
            if (w_start_rise) begin
               w_score1_nxt = '0;
               w_score2_nxt = '0;
               w_cnt_nxt    = c_SERVE_LOAD;
               w_state_nxt  = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (r_cnt == '0) w_state_nxt = ST_PLAY;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         ST_PLAY: begin
            // A simultaneous double miss is a replay with no point awarded.
            if (bus.miss_p1 && bus.miss_p2) begin
               w_cnt_nxt   = c_SERVE_LOAD;
               w_state_nxt = ST_SERVE;
            end else if (bus.miss_p2) begin
               w_score1_nxt = w_inc1;
               if (w_inc1 == c_WIN) begin
                  w_winner_nxt = 1'b0;
                  w_cnt_nxt    = c_HOLD_LOAD;
                  w_state_nxt  = ST_OVER_HOLD;
               end else begin
                  w_cnt_nxt   = c_SERVE_LOAD;
                  w_state_nxt = ST_SERVE;
               end
            end else if (bus.miss_p1) begin
               w_score2_nxt = w_inc2;
               if (w_inc2 == c_WIN) begin
                  w_winner_nxt = 1'b1;
                  w_cnt_nxt    = c_HOLD_LOAD;
                  w_state_nxt  = ST_OVER_HOLD;
               end else begin
                  w_cnt_nxt   = c_SERVE_LOAD;
                  w_state_nxt = ST_SERVE;
               end
            end
         end
         ST_OVER_HOLD: begin
            // Leaving only with restart low keeps a held request from becoming an edge in OVER.
            if (r_cnt != '0)       w_cnt_nxt   = r_cnt - 1'b1;
            else if (!bus.restart) w_state_nxt = ST_OVER;
         end
         ST_OVER: begin
            if (w_restart_rise) begin
               w_score1_nxt = '0;
               w_score2_nxt = '0;
               w_cnt_nxt    = c_SERVE_LOAD;
               w_state_nxt  = ST_SERVE;
            end
         end
         default: w_state_nxt = ST_TITLE;
      endcase
   end

   always_comb begin
      w_pix = bus.rgb_over;
      case (r_state)
         ST_TITLE:          w_pix = bus.rgb_title;
         ST_SERVE, ST_PLAY: w_pix = bus.rgb_play;
         default:           w_pix = bus.rgb_over;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)           r_rgb <= BLACK;
      else if (bus.p_tick) r_rgb <= bus.video_on ? w_pix : BLACK;
   end

   assign bus.rgb         = r_rgb;
   assign bus.game_active = (r_state == ST_PLAY);
   assign bus.ball_reset  = (r_state == ST_TITLE) || (r_state == ST_SERVE);
   assign bus.score1      = r_score1;
   assign bus.score2      = r_score2;
   assign bus.winner      = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Self-checking bench for game_ctrl: directed vector table, corner
//            sequences and random traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

   localparam int WIN = 3;
   localparam int SD  = 4;
   localparam int HO  = 8;

   localparam int M_TITLE = 0;
   localparam int M_SERVE = 1;
   localparam int M_PLAY  = 2;
   localparam int M_HOLD  = 3;
   localparam int M_OVER  = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   game_ctrl_if bus();

   game_ctrl #(
      .WIN_SCORE      (WIN),
      .SERVE_DELAY    (SD),
      .HOLDOFF_CYCLES (HO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: phase, cycles spent in phase, scores, pixel.
   int         m_mode, m_cyc;
   logic [3:0] m_s1, m_s2;
   logic       m_win;
   logic [11:0] m_rgb;
   logic       m_pst, m_prs;

   typedef struct {
      logic       rst, st, rs, m1, m2;
      logic       ga, br;
      logic [3:0] s1, s2;
      logic [11:0] rgb;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic go_serve();
      m_mode = M_SERVE;
      m_cyc  = 0;
   endtask

   task automatic model_step();
      logic [11:0] pix;
      logic srise, rrise;
      if (reset) begin
         m_mode = M_TITLE; m_cyc = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
         m_rgb = 12'h000;  m_pst = 1; m_prs = 1;
      end else begin
         if (m_mode == M_TITLE)                           pix = bus.rgb_title;
         else if (m_mode == M_SERVE || m_mode == M_PLAY)  pix = bus.rgb_play;
         else                                             pix = bus.rgb_over;
         if (bus.p_tick) m_rgb = bus.video_on ? pix : 12'h000;
         srise = bus.start && !m_pst;
         rrise = bus.restart && !m_prs;
         case (m_mode)
            M_TITLE: if (srise) begin m_s1 = 0; m_s2 = 0; go_serve(); end
            M_SERVE: if (m_cyc == SD - 1) begin m_mode = M_PLAY; m_cyc = 0; end
                     else m_cyc++;
            M_PLAY: begin
               if (bus.miss_p1 && bus.miss_p2) go_serve();
               else if (bus.miss_p2) begin
                  if (m_s1 < WIN) m_s1 = m_s1 + 1;
                  if (m_s1 == WIN) begin m_win = 0; m_mode = M_HOLD; m_cyc = 0; end
                  else go_serve();
               end else if (bus.miss_p1) begin
                  if (m_s2 < WIN) m_s2 = m_s2 + 1;
                  if (m_s2 == WIN) begin m_win = 1; m_mode = M_HOLD; m_cyc = 0; end
                  else go_serve();
               end
            end
            M_HOLD: begin
               if (m_cyc >= HO - 1 && !bus.restart) m_mode = M_OVER;
               else if (m_cyc < HO - 1) m_cyc++;
            end
            default: if (rrise) begin m_s1 = 0; m_s2 = 0; go_serve(); end
         endcase
         m_pst = bus.start;
         m_prs = bus.restart;
      end
   endtask

   // Advance one clock with the current inputs, then compare against the model.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("game_active", bus.game_active, m_mode == M_PLAY);
      chk("ball_reset",  bus.ball_reset,  m_mode == M_TITLE || m_mode == M_SERVE);
      chk("score1",      bus.score1,      m_s1);
      chk("score2",      bus.score2,      m_s2);
      chk("rgb",         bus.rgb,         m_rgb);
      if (m_mode == M_HOLD || m_mode == M_OVER) chk("winner", bus.winner, m_win);
   endtask

   task automatic wait_play();
      for (int i = 0; i < 20 && !bus.game_active; i++) cycle();
      chk("reach_play", bus.game_active, 1'b1);
   endtask

   task automatic set_vec(input int i, input logic rst, st, m2,
                          input logic ga, br, input logic [3:0] s1,
                          input logic [11:0] rgb);
      tbl[i] = '{rst: rst, st: st, rs: 1'b0, m1: 1'b0, m2: m2,
                 ga: ga, br: br, s1: s1, s2: 4'd0, rgb: rgb};
   endtask

   initial begin
      bus.p_tick = 1; bus.video_on = 1; bus.start = 1; bus.restart = 0;
      bus.miss_p1 = 0; bus.miss_p2 = 0;
      bus.rgb_title = 12'h111; bus.rgb_play = 12'h222; bus.rgb_over = 12'h333;

      // Reset with start held, fresh press, serve, three points to player 1.
      set_vec(0, 1, 1, 0, 0, 1, 0, 12'h000);
      set_vec(1, 0, 1, 0, 0, 1, 0, 12'h111);
      set_vec(2, 0, 0, 0, 0, 1, 0, 12'h111);
      set_vec(3, 0, 1, 0, 0, 1, 0, 12'h111);
      for (int i = 4; i < 7; i++) set_vec(i, 0, 0, 0, 0, 1, 0, 12'h222);
      set_vec(7, 0, 0, 0, 1, 0, 0, 12'h222);
      set_vec(8, 0, 0, 1, 0, 1, 1, 12'h222);
      for (int i = 9; i < 12; i++) set_vec(i, 0, 0, 0, 0, 1, 1, 12'h222);
      set_vec(12, 0, 0, 0, 1, 0, 1, 12'h222);
      set_vec(13, 0, 0, 1, 0, 1, 2, 12'h222);
      for (int i = 14; i < 17; i++) set_vec(i, 0, 0, 0, 0, 1, 2, 12'h222);
      set_vec(17, 0, 0, 0, 1, 0, 2, 12'h222);
      set_vec(18, 0, 0, 1, 0, 0, 3, 12'h222);
      set_vec(19, 0, 0, 0, 0, 0, 3, 12'h333);

      #2;
      for (int i = 0; i < 20; i++) begin
         reset = tbl[i].rst; bus.start = tbl[i].st; bus.restart = tbl[i].rs;
         bus.miss_p1 = tbl[i].m1; bus.miss_p2 = tbl[i].m2;
         cycle();
         chk($sformatf("tbl%0d_ga", i),  bus.game_active, tbl[i].ga);
         chk($sformatf("tbl%0d_br", i),  bus.ball_reset,  tbl[i].br);
         chk($sformatf("tbl%0d_s1", i),  bus.score1,      tbl[i].s1);
         chk($sformatf("tbl%0d_s2", i),  bus.score2,      tbl[i].s2);
         chk($sformatf("tbl%0d_rgb", i), bus.rgb,         tbl[i].rgb);
      end
      chk("winner_p1", bus.winner, 1'b0);

      // Restart pulse inside the hold-off window must be ignored.
      bus.restart = 1; cycle();
      bus.restart = 0; cycle(); cycle();
      chk("hold_pulse_br", bus.ball_reset, 1'b0);
      // Restart held well past hold-off keeps the controller in hold.
      bus.restart = 1;
      for (int i = 0; i < 12; i++) cycle();
      bus.restart = 0; cycle();
      // Fresh restart edge in OVER starts a new game.
      bus.restart = 1; cycle();
      chk("restart_serve", bus.ball_reset, 1'b1);
      chk("restart_s1", bus.score1, 4'd0);
      bus.restart = 0;
      wait_play();
      bus.miss_p1 = 1; bus.miss_p2 = 1; cycle();
      bus.miss_p1 = 0; bus.miss_p2 = 0;
      chk("double_miss_serve", bus.ball_reset, 1'b1);
      chk("double_miss_s1", bus.score1, 4'd0);
      chk("double_miss_s2", bus.score2, 4'd0);
      wait_play();

      // Blanking and pixel-tick gating.
      bus.video_on = 0; bus.rgb_play = 12'hFFF; cycle();
      chk("blank_rgb", bus.rgb, 12'h000);
      bus.video_on = 1; bus.p_tick = 0; bus.rgb_play = 12'hABC; cycle();
      chk("no_tick_rgb", bus.rgb, 12'h000);
      bus.rgb_play = 12'h5A5; cycle();
      chk("no_tick_rgb2", bus.rgb, 12'h000);
      bus.p_tick = 1; cycle();
      chk("tick_rgb", bus.rgb, 12'h5A5);

      // Two points to player 2, then reset mid-play.
      bus.miss_p1 = 1; cycle(); bus.miss_p1 = 0;
      wait_play();
      bus.miss_p1 = 1; cycle(); bus.miss_p1 = 0;
      wait_play();
      chk("pre_reset_s2", bus.score2, 4'd2);
      reset = 1; cycle(); reset = 0;
      chk("rst_br", bus.ball_reset, 1'b1);
      chk("rst_ga", bus.game_active, 1'b0);
      chk("rst_s2", bus.score2, 4'd0);
      chk("rst_rgb", bus.rgb, 12'h000);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         reset         = ($urandom_range(0, 199) == 0);
         bus.start     = ($urandom_range(0, 3) == 0);
         bus.restart   = ($urandom_range(0, 3) == 0);
         bus.miss_p1   = ($urandom_range(0, 5) == 0);
         bus.miss_p2   = ($urandom_range(0, 5) == 0);
         bus.p_tick    = $urandom_range(0, 1) == 1;
         bus.video_on  = ($urandom_range(0, 3) != 0);
         bus.rgb_title = 12'($urandom);
         bus.rgb_play  = 12'($urandom);
         bus.rgb_over  = 12'($urandom);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game flow controller, directly downstream of the game-over screen renderer.
- Consumes the renderer's `restart` request and pixel stream, plus the title and play-field pixel streams and miss events from the ball logic.
- Sequences TITLE -> SERVE -> PLAY -> OVER, keeps both scores, gates ball/paddle motion, and drives the single registered RGB output to the VGA pins.

Parameters:
- WIN_SCORE, 7: points needed to win; legal range 1..15.
- SERVE_DELAY, 25_000_000: clk cycles the ball is held at centre before each serve.
- HOLDOFF_CYCLES, 25_000_000: clk cycles after entering game-over during which restart is ignored.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- p_tick  input  1  pixel-rate enable from the sync generator.
- video_on  input  1  active-video flag from the sync generator.
- start  input  1  enter button, level; synchronous to clk and debounced upstream.
- restart  input  1  level request from the game-over renderer.
- miss_p1  input  1  one-cycle pulse: ball passed player 1's paddle.
- miss_p2  input  1  one-cycle pulse: ball passed player 2's paddle.
- rgb_title  input  12  title-screen pixel.
- rgb_play  input  12  play-field pixel.
- rgb_over  input  12  game-over pixel.
- rgb  output  12  registered pixel to the DAC.
- game_active  output  1  high only in PLAY; enables ball and paddle motion.
- ball_reset  output  1  high in TITLE and SERVE; holds the ball at centre.
- score1  output  4  player 1 score.
- score2  output  4  player 2 score.
- winner  output  1  0 = player 1, 1 = player 2; valid in OVER_HOLD and OVER.

Behaviour:
- Reset (synchronous, active-high) sets:
  - state = TITLE
  - score1 = score2 = 0, winner = 0, rgb = 0
  - ball_reset = 1, game_active = 0
  - all counters = 0, edge-detect history = 1 (so a button held through reset produces no edge)
- Edge detection:
  - start_rise = start & ~start_q; restart_rise = restart & ~restart_q.
  - Both history registers update every clk, not gated by p_tick.
- States and transitions:
  - TITLE: on start_rise, clear both scores, load the serve counter, go to SERVE.
  - SERVE: count down SERVE_DELAY cycles; at terminal count go to PLAY. Total cycles in SERVE = SERVE_DELAY exactly. Miss pulses are ignored.
  - PLAY, miss handling:
    - miss_p1 alone: score2 += 1.
    - miss_p2 alone: score1 += 1.
    - Both in the same cycle: neither scores; go to SERVE (replay).
  - PLAY, after a scoring miss:
    - If the incremented score == WIN_SCORE: set winner, go to OVER_HOLD.
    - Otherwise go to SERVE. The score register updates in the same cycle as the state change.
  - OVER_HOLD: count HOLDOFF_CYCLES, ignoring restart and start. At terminal count go to OVER, but only if restart is low that cycle; otherwise stay until restart is low.
  - OVER: on restart_rise, clear scores, load the serve counter, go to SERVE. Scores and winner stay frozen until then.
- Scores saturate at WIN_SCORE and never wrap. Score arithmetic is 4-bit unsigned.
- Outputs:
  - game_active and ball_reset are Moore outputs decoded from registered state (no combinational input path).
- RGB select:
  - TITLE: rgb_title. SERVE and PLAY: rgb_play. OVER_HOLD and OVER: rgb_over.
  - Forced to 0 when video_on = 0.
  - rgb is loaded only when p_tick = 1, giving one pixel of latency from the selected input.
- Reset asserted mid-game returns to TITLE on the next clk regardless of state or counters.
- Counter widths are $clog2 of the larger delay parameter plus 1.

Decomposition:
- Shared package (game_pkg):
  - State encoding: TITLE, SERVE, PLAY, OVER_HOLD, OVER.
  - RGB_W = 12 and BLACK = 12'h000.
  - Score width 4.
- One natural sub-module: edge_rise (registered rising-edge detector with history reset-to-1), instanced for start and restart.
- The FSM, counters, scores and RGB mux stay in game_ctrl.

Test Plan (bench overrides: WIN_SCORE = 3, SERVE_DELAY = 4, HOLDOFF_CYCLES = 8):
1. Reset with start held high, then release and press start: no transition until the new edge. After the press: SERVE for exactly 4 clk with ball_reset = 1, then PLAY with game_active = 1, ball_reset = 0.
2. Three miss_p2 pulses, each issued in PLAY: score1 = 1, 2, 3. After the third: OVER_HOLD, winner = 0, rgb follows rgb_over at the next p_tick. After each of the first two misses the controller returns to SERVE.
3. restart held high through OVER_HOLD: stays past 8 clk; moves to OVER one clk after restart drops. A single restart pulse during OVER_HOLD is ignored.
4. In OVER, a restart pulse: SERVE with score1 = score2 = 0. Then miss_p1 and miss_p2 in the same PLAY cycle: scores unchanged, back to SERVE.
5. video_on = 0 with rgb_play = 12'hFFF: rgb = 0. Changing rgb_play between p_ticks: rgb changes only on the p_tick cycle.
6. reset pulsed in PLAY with score2 = 2: next clk state = TITLE, scores 0, rgb 0, ball_reset = 1.
